// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART_tx among NUM_REQ packet sources. Grants change only
// at packet boundaries; bytes are handed over via tx_data/trmt/tx_done with a stall watchdog.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TX_TIMEOUT = 1048576
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] byte_data,
    input  logic [NUM_REQ-1:0]   byte_vld,
    input  logic [NUM_REQ-1:0]   byte_last,
    output logic [NUM_REQ-1:0]   byte_ack,
    output logic [NUM_REQ-1:0]   grant,
    output logic [7:0]           tx_data,
    output logic                 trmt,
    input  logic                 tx_done,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned       IDX_W    = $clog2(NUM_REQ);
    localparam int unsigned       WD_W     = $clog2(TX_TIMEOUT);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TX_TIMEOUT - 1);
    localparam logic [WD_W-1:0]   WD_MAX   = '1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StWait
    } state_e;

    state_e           state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [WD_W-1:0]  wd_cnt_q;
    logic             last_flag_q;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       own_data;
    logic             own_vld;
    logic             own_last;
    logic             own_req;

    // First pending requester after rr_ptr, wrapping around.
    always_comb begin
        int unsigned cand;
        logic [IDX_W-1:0] cand_idx;
        pick_vld = 1'b0;
        pick_idx = '0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand     = (32'(rr_ptr_q) + k) % NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!pick_vld && req[cand_idx]) begin
                pick_vld = 1'b1;
                pick_idx = cand_idx;
            end
        end
    end

    always_comb begin
        own_data = 8'h00;
        own_vld  = 1'b0;
        own_last = 1'b0;
        own_req  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                own_data = byte_data[8*i +: 8];
                own_vld  = byte_vld[i];
                own_last = byte_last[i];
                own_req  = req[i];
            end
        end
    end

    assign byte_ack = (state_q == StSend) ? (grant & byte_vld) : '0;
    assign busy     = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= '0;
            rr_ptr_q    <= LAST_IDX;
            wd_cnt_q    <= '0;
            last_flag_q <= 1'b0;
            grant       <= '0;
            tx_data     <= 8'h00;
            trmt        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            trmt        <= 1'b0;
            timeout_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (pick_vld) begin
                        owner_q <= pick_idx;
                        grant   <= NUM_REQ'(1) << pick_idx;
                        state_q <= StSend;
                    end
                end
                StSend: begin
                    if (own_vld) begin
                        tx_data     <= own_data;
                        last_flag_q <= own_last;
                        trmt        <= 1'b1;
                        wd_cnt_q    <= '0;
                        state_q     <= StWait;
                    end else if (!own_req) begin
                        grant    <= '0;
                        rr_ptr_q <= owner_q;
                        state_q  <= StIdle;
                    end
                end
                StWait: begin
                    if (wd_cnt_q != WD_MAX) begin
                        wd_cnt_q <= wd_cnt_q + 1'b1;
                    end
                    // UART_tx clears tx_done while trmt is high, so that cycle is skipped.
                    if (!trmt) begin
                        if (tx_done) begin
                            wd_cnt_q <= '0;
                            if (last_flag_q) begin
                                grant    <= '0;
                                rr_ptr_q <= owner_q;
                                state_q  <= StIdle;
                            end else begin
                                state_q <= StSend;
                            end
                        end else if (wd_cnt_q == WD_LAST) begin
                            wd_cnt_q    <= '0;
                            timeout_err <= 1'b1;
                            grant       <= '0;
                            rr_ptr_q    <= owner_q;
                            state_q     <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
